mem_router: RTL and testbench

- Parametrised, registered successor to the combinational CPU memory decoder in the DE0 top level.
- Decodes the 20-bit CPU address into up to 4 memory regions, each with its own base, mask and wait-state count.
- Drives one-hot select and write strobes, captures read data into a register, and stalls the CPU with cpu_ready while an access is in progress.
- Sits between core and the m256k/m16k/m8k memories; unmapped reads return DEFAULT_DATA.

---
 rtl/mem_router_if.sv | 32 +++
 rtl/mem_router.sv | 175 +++++++++++++++++
 tb/tb_mem_router.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_router_if.sv
// Bus bundle between the CPU, mem_router and the region memories.
// slave is the router's view; master is the CPU/memory environment's view.
interface mem_router_if #(
    parameter int AW = 20,
    parameter int DW = 8
);
    // A request (cpu_rd | cpu_we) is taken on an edge where cpu_ready is high; the CPU holds it until then.
    logic [AW-1:0]   cpu_address;
    logic            cpu_rd;
    logic            cpu_we;
    logic [DW-1:0]   cpu_out;
    logic [DW-1:0]   cpu_in;
    logic            cpu_ready;
    logic [AW-1:0]   mem_address;
    logic [DW-1:0]   mem_d;
    logic [3:0]      mem_sel;
    logic [3:0]      mem_we;
    logic [4*DW-1:0] mem_q;
    logic            fault;
    logic [AW-1:0]   fault_addr;
    logic            fault_clr;

    modport slave (
        input  cpu_address, cpu_rd, cpu_we, cpu_out, mem_q, fault_clr,
        output cpu_in, cpu_ready, mem_address, mem_d, mem_sel, mem_we, fault, fault_addr
    );

    modport master (
        output cpu_address, cpu_rd, cpu_we, cpu_out, mem_q, fault_clr,
        input  cpu_in, cpu_ready, mem_address, mem_d, mem_sel, mem_we, fault, fault_addr
    );
endinterface

// File: rtl/mem_router.sv
// Registered CPU memory router: decodes up to 4 regions with per-region wait states.
// Optional sticky unmapped-access fault capture is enabled by defining MEM_ROUTER_FAULT_EN.
module mem_router #(
    parameter int            AW           = 20,
    parameter int            DW           = 8,
    parameter int            REGIONS      = 3,
    parameter logic [AW-1:0] BASE0        = 20'h00000,
    parameter logic [AW-1:0] BASE1        = 20'hA0000,
    parameter logic [AW-1:0] BASE2        = 20'hFE000,
    parameter logic [AW-1:0] BASE3        = 20'h00000,
    parameter logic [AW-1:0] MASK0        = 20'hC0000,
    parameter logic [AW-1:0] MASK1        = 20'hFC000,
    parameter logic [AW-1:0] MASK2        = 20'hFE000,
    parameter logic [AW-1:0] MASK3        = 20'h00000,
    parameter int            WAIT0        = 0,
    parameter int            WAIT1        = 1,
    parameter int            WAIT2        = 2,
    parameter int            WAIT3        = 0,
    parameter logic [DW-1:0] DEFAULT_DATA = 8'hFF
) (
    input  logic         clock,
    input  logic         reset,
    mem_router_if.slave  bus,
    output logic         dbg_state_o
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [4*AW-1:0] BASES    = {BASE3, BASE2, BASE1, BASE0};
    localparam logic [4*AW-1:0] MASKS    = {MASK3, MASK2, MASK1, MASK0};
    localparam logic [11:0]     WAITS    = {3'(WAIT3), 3'(WAIT2), 3'(WAIT1), 3'(WAIT0)};
    localparam logic [3:0]      REG_MASK = 4'((1 << REGIONS) - 1);

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          is_wr_q, is_wr_d;
    logic [3:0]    sel_q, sel_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_in_q, cpu_in_d;
    logic [3:0]    hit_sel;
    logic [2:0]    hit_wait;
    logic [DW-1:0] rd_data;
    logic          accept, finish;
    logic          ready, busy;
    logic [3:0]    we_out;

    assign accept = (state_q == IDLE) && (bus.cpu_rd || bus.cpu_we);
    assign finish = (state_q == BUSY) && (cnt_q == 3'd0);

    // Walking downward lets the lowest hitting region overwrite the others.
    always_comb begin
        hit_sel  = '0;
        hit_wait = '0;
        for (int n = 3; n >= 0; n--) begin
            if (n < REGIONS && (bus.cpu_address & MASKS[n*AW +: AW]) == BASES[n*AW +: AW]) begin
                hit_sel    = '0;
                hit_sel[n] = 1'b1;
                hit_wait   = WAITS[n*3 +: 3];
            end
        end
    end

    always_comb begin
        rd_data = DEFAULT_DATA;
        for (int n = 0; n < 4; n++) begin
            if (sel_q[n]) rd_data = bus.mem_q[n*DW +: DW];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready  = (state_q == IDLE);
        busy   = (state_q == BUSY);
        we_out = (finish && is_wr_q) ? (sel_q & REG_MASK) : 4'b0000;
    end

    always_comb begin
        cnt_d    = cnt_q;
        is_wr_d  = is_wr_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cpu_in_d = cpu_in_q;
        if (accept) begin
            addr_d  = bus.cpu_address;
            wdata_d = bus.cpu_out;
            is_wr_d = bus.cpu_we;
            sel_d   = hit_sel;
            cnt_d   = hit_wait;
        end else if (state_q == BUSY) begin
            if (cnt_q != 3'd0) begin
                cnt_d = cnt_q - 3'd1;
            end else begin
                sel_d = '0;
                if (!is_wr_q) cpu_in_d = rd_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            is_wr_q  <= 1'b0;
            sel_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cpu_in_q <= DEFAULT_DATA;
        end else begin
            cnt_q    <= cnt_d;
            is_wr_q  <= is_wr_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cpu_in_q <= cpu_in_d;
        end
    end

    assign bus.cpu_ready   = ready;
    assign bus.cpu_in      = cpu_in_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_d       = wdata_q;
    assign bus.mem_sel     = sel_q & REG_MASK;
    assign bus.mem_we      = we_out;
    assign dbg_state_o     = busy;

`ifdef MEM_ROUTER_FAULT_EN
    logic          fault_q, fault_d;
    logic [AW-1:0] fault_addr_q, fault_addr_d;

    // A fresh fault beats a coincident clear, so the capture is applied last.
    always_comb begin
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        if (bus.fault_clr) begin
            fault_d      = 1'b0;
            fault_addr_d = '0;
        end
        if (accept && hit_sel == 4'b0000 && (!fault_q || bus.fault_clr)) begin
            fault_d      = 1'b1;
            fault_addr_d = bus.cpu_address;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign bus.fault      = fault_q;
    assign bus.fault_addr = fault_addr_q;
`else
    logic unused_fault_clr;
    assign unused_fault_clr = bus.fault_clr;
    assign bus.fault        = 1'b0;
    assign bus.fault_addr   = '0;
`endif
endmodule

// File: tb/tb_mem_router.sv
// Directed bench for mem_router: region decode, wait-state timing, strobes, reset abort.
// Fault checks follow MEM_ROUTER_FAULT_EN when it is defined for the build.
module tb_mem_router;
    logic clock;
    logic reset;
    logic dbg_state;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] exp_q[$];

    int         low_cycles, we_cycles, we_at;
    logic [3:0] we_val, sel_seen;

    mem_router_if #(.AW(20), .DW(8)) bus ();

    mem_router dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one request and watch it complete; sampling happens on negedges.
    task automatic access(input logic rd, input logic we, input logic [19:0] addr, input logic [7:0] wdata);
        @(negedge clock);
        bus.cpu_rd      = rd;
        bus.cpu_we      = we;
        bus.cpu_address = addr;
        bus.cpu_out     = wdata;
        @(posedge clock);
        @(negedge clock);
        bus.cpu_rd = 1'b0;
        bus.cpu_we = 1'b0;
        sel_seen   = bus.mem_sel;
        low_cycles = 0;
        we_cycles  = 0;
        we_at      = -1;
        we_val     = 4'b0000;
        while (bus.cpu_ready == 1'b0 && low_cycles < 20) begin
            low_cycles++;
            if (bus.mem_we != 4'b0000) begin
                we_cycles++;
                we_val = bus.mem_we;
                we_at  = low_cycles;
            end
            @(negedge clock);
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.cpu_rd      = 1'b0;
        bus.cpu_we      = 1'b0;
        bus.cpu_address = '0;
        bus.cpu_out     = '0;
        bus.fault_clr   = 1'b0;
        bus.mem_q       = {8'h00, 8'hEA, 8'h77, 8'h5A};
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_ready", bus.cpu_ready, 1);
        check("rst_cpu_in", bus.cpu_in, 8'hFF);
        check("rst_sel", bus.mem_sel, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_addr", bus.mem_address, 0);
        check("rst_d", bus.mem_d, 0);
        check("rst_fault", bus.fault, 0);
        check("rst_fault_addr", bus.fault_addr, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b0;

        // region 0 read, no wait states
        exp_q.push_back(8'h5A);
        access(1'b1, 1'b0, 20'h12345, 8'h00);
        check("r0_sel", sel_seen, 4'b0001);
        check("r0_low", low_cycles, 1);
        check("r0_we", we_cycles, 0);
        check("r0_data", bus.cpu_in, exp_q.pop_front());
        check("r0_addr", bus.mem_address, 20'h12345);
        check("r0_sel_after", bus.mem_sel, 0);

        // region 1 write, one wait state
        access(1'b0, 1'b1, 20'hA0010, 8'h3C);
        check("w1_sel", sel_seen, 4'b0010);
        check("w1_low", low_cycles, 2);
        check("w1_we_cnt", we_cycles, 1);
        check("w1_we_val", we_val, 4'b0010);
        check("w1_we_at", we_at, 2);
        check("w1_d", bus.mem_d, 8'h3C);
        check("w1_cpu_in_held", bus.cpu_in, 8'h5A);
        check("w1_addr_held", bus.mem_address, 20'hA0010);

        // region 2 read, two wait states
        exp_q.push_back(8'hEA);
        access(1'b1, 1'b0, 20'hFE100, 8'h00);
        check("r2_sel", sel_seen, 4'b0100);
        check("r2_low", low_cycles, 3);
        check("r2_data", bus.cpu_in, exp_q.pop_front());

        // unmapped read; region 3 matches every address but is beyond REGIONS
        exp_q.push_back(8'hFF);
        access(1'b1, 1'b0, 20'h80000, 8'h00);
        check("um_sel", sel_seen, 4'b0000);
        check("um_low", low_cycles, 1);
        check("um_data", bus.cpu_in, exp_q.pop_front());
`ifdef MEM_ROUTER_FAULT_EN
        check("um_fault", bus.fault, 1);
        check("um_fault_addr", bus.fault_addr, 20'h80000);
        access(1'b1, 1'b0, 20'hC0000, 8'h00);
        check("um2_fault_addr", bus.fault_addr, 20'h80000);
        bus.fault_clr = 1'b1;
        @(negedge clock);
        bus.fault_clr = 1'b0;
        check("clr_fault", bus.fault, 0);
        check("clr_fault_addr", bus.fault_addr, 0);
`else
        check("um_fault_off", bus.fault, 0);
        check("um_fault_addr_off", bus.fault_addr, 0);
`endif

        // rd and we together behave as a write
        access(1'b1, 1'b1, 20'h00001, 8'hA5);
        check("rw_sel", sel_seen, 4'b0001);
        check("rw_low", low_cycles, 1);
        check("rw_we_val", we_val, 4'b0001);
        check("rw_we_cnt", we_cycles, 1);
        check("rw_d", bus.mem_d, 8'hA5);
        check("rw_cpu_in", bus.cpu_in, 8'hFF);

        // held request is not re-accepted on the completion edge
        @(negedge clock);
        bus.cpu_rd      = 1'b1;
        bus.cpu_address = 20'h00020;
        @(negedge clock);
        check("b2b_busy", bus.cpu_ready, 0);
        @(negedge clock);
        check("b2b_gap", bus.cpu_ready, 1);
        check("b2b_data", bus.cpu_in, 8'h5A);
        @(negedge clock);
        check("b2b_second", bus.cpu_ready, 0);
        bus.cpu_rd = 1'b0;
        @(negedge clock);
        check("b2b_done", bus.cpu_ready, 1);

        // reset during the first busy cycle of a region-2 write
        @(negedge clock);
        bus.cpu_we      = 1'b1;
        bus.cpu_address = 20'hFE000;
        bus.cpu_out     = 8'h11;
        @(posedge clock);
        @(negedge clock);
        bus.cpu_we = 1'b0;
        check("ra_busy", bus.cpu_ready, 0);
        check("ra_sel_busy", bus.mem_sel, 4'b0100);
        #1 reset = 1'b1;
        #1;
        check("ra_ready", bus.cpu_ready, 1);
        check("ra_sel", bus.mem_sel, 0);
        check("ra_cpu_in", bus.cpu_in, 8'hFF);
        we_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i == 1) reset = 1'b0;
            if (bus.mem_we != 4'b0000 || bus.cpu_ready != 1'b1) we_cycles++;
        end
        check("ra_no_strobe_retry", we_cycles, 0);
        check("ra_state", dbg_state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
